// File: rtl/fsk_tx_pkg.sv
// Shared state type and widths for the 4FSK transmit frame scheduler.
// Used by fsk_tx_sched and sym_timer.
package fsk_tx_pkg;

    localparam int unsigned SYM_BITS = 16;
    localparam int unsigned PHASE_W  = 8;
    localparam int unsigned CNT_W    = 4;

    localparam logic [SYM_BITS-1:0] SYNC_WORD_DEFAULT = 16'hF0A5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2
    } tx_state_t;

endpackage

// File: rtl/sym_timer.sv
// Symbol timer: phase counts clk_sys cycles within a symbol and sign_cnt
// counts symbols within a 16-symbol section. Held at zero while clear is high.
module sym_timer
    import fsk_tx_pkg::*;
#(
    parameter int unsigned SYM_LEN = 256
) (
    input  logic               clk_sys,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               run,
    output logic [PHASE_W-1:0] phase,
    output logic [CNT_W-1:0]   sign_cnt,
    output logic               sym_end,
    output logic               sect_end
);

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(SYM_LEN - 1);

    assign sym_end  = run && (phase == PHASE_LAST);
    assign sect_end = sym_end && (sign_cnt == '1);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= '0;
            sign_cnt <= '0;
        end else if (clear) begin
            phase    <= '0;
            sign_cnt <= '0;
        end else if (run) begin
            if (sym_end) begin
                phase    <= '0;
                sign_cnt <= sign_cnt + 1'b1;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fsk_tx_sched.sv
// 4FSK transmit frame scheduler: round-robin word arbiter, frame FSM and
// symbol-rate serialiser. Define FSK_TX_PREAMBLE_EN to prefix each frame with SYNC_WORD.
module fsk_tx_sched
    import fsk_tx_pkg::*;
#(
    parameter int unsigned          SYM_LEN   = 256,
    parameter logic [SYM_BITS-1:0]  SYNC_WORD = SYNC_WORD_DEFAULT,
    parameter logic                 IDLE_BIT  = 1'b0
) (
    input  logic                clk_sys,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    input  logic [SYM_BITS-1:0] req_word0,
    input  logic [SYM_BITS-1:0] req_word1,
    output logic [1:0]          req_ready,
    output logic                out_bit,
    output logic                tx_en,
    output logic [PHASE_W-1:0]  phase,
    output logic [CNT_W-1:0]    sign_cnt,
    output logic                sign_clk,
    output logic                grant_id,
    output logic                frame_done
);

    tx_state_t           state_q;
    tx_state_t           state_d;
    logic [SYM_BITS-1:0] word_q;
    logic                grant_q;
    logic                last_q;
    logic                done_q;
    logic [1:0]          win;
    logic                win_id;
    logic                accept;
    logic                sym_end;
    logic                sect_end;

    // last_q resets to 1 so that requester 0 takes the first tie.
    always_comb begin
        win = '0;
        case (req_valid)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last_q ? 2'b01 : 2'b10;
            default: win = '0;
        endcase
    end

    // ready is combinational from req_valid, so it is also masked while reset is held.
    assign req_ready = ((state_q == IDLE) && rst_n) ? win : '0;
    assign win_id    = req_ready[1];
    assign accept    = |(req_valid & req_ready);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef FSK_TX_PREAMBLE_EN
                    state_d = SYNC;
`else
                    state_d = DATA;
`endif
                end
            end
            SYNC: begin
                if (sym_end && sect_end) state_d = DATA;
            end
            DATA: begin
                if (sym_end && sect_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_bit = IDLE_BIT;
        case (state_q)
            SYNC:    out_bit = SYNC_WORD[sign_cnt];
            DATA:    out_bit = word_q[sign_cnt];
            default: out_bit = IDLE_BIT;
        endcase
    end

    assign tx_en      = (state_q != IDLE);
    assign sign_clk   = tx_en && (phase == '0);
    assign grant_id   = grant_q;
    assign frame_done = done_q;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == DATA) && (state_d == IDLE);
            if (accept) begin
                word_q  <= win_id ? req_word1 : req_word0;
                grant_q <= win_id;
                last_q  <= win_id;
            end
        end
    end

    sym_timer #(
        .SYM_LEN (SYM_LEN)
    ) u_sym_timer (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .clear    (state_q == IDLE),
        .run      (tx_en),
        .phase    (phase),
        .sign_cnt (sign_cnt),
        .sym_end  (sym_end),
        .sect_end (sect_end)
    );

endmodule
